// File: rtl/xconnect_gather.sv
// Receive-side reorder buffer for the xconnect butterfly interconnect.
// Collects NOF_PES beats per PE into a double-buffered store and replays each frame in source order.

module xconnect_gather_lane #(
  parameter int WORD_SIZE  = 256,
  parameter int NOF_PES    = 16,
  parameter int NOF_LEVELS = $clog2(NOF_PES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_bank,
  input  logic [NOF_LEVELS-1:0] wr_src,
  input  logic [WORD_SIZE-1:0]  wr_word,
  input  logic                  clr_en,
  input  logic                  rd_bank,
  input  logic [NOF_LEVELS-1:0] rd_idx,
  input  logic                  rd_en,
  output logic [WORD_SIZE-1:0]  rd_word,
  output logic                  rd_filled
);
  logic [WORD_SIZE-1:0]        mem [2][NOF_PES];
  logic [1:0][NOF_PES-1:0]     filled;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_src] <= wr_word;
  end

  // Clear targets the bank being drained; writes only ever target the other bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filled <= '0;
    end else begin
      if (clr_en) filled[rd_bank] <= '0;
      if (wr_en)  filled[wr_bank][wr_src] <= 1'b1;
    end
  end

  // Unfilled slots read as zero so stale data from an earlier frame never leaks out.
  assign rd_filled = rd_en & filled[rd_bank][rd_idx];
  assign rd_word   = rd_filled ? mem[rd_bank][rd_idx] : '0;
endmodule

module xconnect_gather #(
  parameter int WORD_SIZE  = 256,
  parameter int NOF_PES    = 16,
  parameter int NOF_LEVELS = $clog2(NOF_PES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WORD_SIZE*NOF_PES-1:0]     in_pes_data,
  input  logic [NOF_LEVELS*NOF_PES-1:0]    in_src_connectivity,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORD_SIZE*NOF_PES-1:0]     out_pes_data,
  output logic [NOF_PES-1:0]               out_word_valid,
  output logic [NOF_LEVELS-1:0]            out_src_idx,
  output logic                             out_last,
  output logic [15:0]                      frames_done
);
  localparam logic [NOF_LEVELS-1:0] CNT_MAX = NOF_LEVELS'(NOF_PES - 1);

  typedef struct packed {
    logic [1:0]            full;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [NOF_LEVELS-1:0] wr_cnt;
    logic [NOF_LEVELS-1:0] rd_cnt;
  } bank_state_t;

  bank_state_t st, st_nxt;
  logic wr_fire, rd_fire, wr_last, rd_last;

  logic [NOF_PES-1:0][WORD_SIZE-1:0]  in_words, out_words;
  logic [NOF_PES-1:0][NOF_LEVELS-1:0] in_srcs;

  assign in_words     = in_pes_data;
  assign in_srcs      = in_src_connectivity;
  assign out_pes_data = out_words;

  assign in_ready    = ~st.full[st.wr_bank];
  assign out_valid   = st.full[st.rd_bank];
  assign out_src_idx = st.rd_cnt;
  assign out_last    = out_valid & (st.rd_cnt == CNT_MAX);

  assign wr_fire = in_valid & in_ready;
  assign rd_fire = out_valid & out_ready;
  assign wr_last = wr_fire & (st.wr_cnt == CNT_MAX);
  assign rd_last = rd_fire & out_last;

  // Counters wrap naturally at NOF_PES since it is a power of two.
  always_comb begin
    st_nxt = st;
    if (wr_fire) st_nxt.wr_cnt = st.wr_cnt + 1'b1;
    if (wr_last) begin
      st_nxt.full[st.wr_bank] = 1'b1;
      st_nxt.wr_bank          = ~st.wr_bank;
    end
    if (rd_fire) st_nxt.rd_cnt = st.rd_cnt + 1'b1;
    if (rd_last) begin
      st_nxt.full[st.rd_bank] = 1'b0;
      st_nxt.rd_bank          = ~st.rd_bank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= '0;
      frames_done <= '0;
    end else begin
      st <= st_nxt;
      if (rd_last) frames_done <= frames_done + 16'd1;
    end
  end

  for (genvar p = 0; p < NOF_PES; p++) begin : g_lane
    xconnect_gather_lane #(
      .WORD_SIZE (WORD_SIZE),
      .NOF_PES   (NOF_PES),
      .NOF_LEVELS(NOF_LEVELS)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_fire),
      .wr_bank  (st.wr_bank),
      .wr_src   (in_srcs[p]),
      .wr_word  (in_words[p]),
      .clr_en   (rd_last),
      .rd_bank  (st.rd_bank),
      .rd_idx   (st.rd_cnt),
      .rd_en    (out_valid),
      .rd_word  (out_words[p]),
      .rd_filled(out_word_valid[p])
    );
  end
endmodule

// File: tb/tb_xconnect_gather.sv
// Scoreboard bench for xconnect_gather with 4 PEs of 8-bit words.
module tb_xconnect_gather;
  localparam int W  = 8;
  localparam int NP = 4;
  localparam int NL = 2;

  logic            clk = 0, rst = 0;
  logic            in_valid = 0, in_ready;
  logic [W*NP-1:0] in_pes_data = '0;
  logic [NL*NP-1:0] in_src_connectivity = '0;
  logic            out_valid, out_ready = 0;
  logic [W*NP-1:0] out_pes_data;
  logic [NP-1:0]   out_word_valid;
  logic [NL-1:0]   out_src_idx;
  logic            out_last;
  logic [15:0]     frames_done;

  xconnect_gather #(.WORD_SIZE(W), .NOF_PES(NP), .NOF_LEVELS(NL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pes_data(in_pes_data), .in_src_connectivity(in_src_connectivity),
    .out_valid(out_valid), .out_ready(out_ready), .out_pes_data(out_pes_data),
    .out_word_valid(out_word_valid), .out_src_idx(out_src_idx),
    .out_last(out_last), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W*NP-1:0] data;
    logic [NP-1:0]   wv;
    logic [NL-1:0]   src;
    logic            last;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0, errors = 0;
  int stall_cnt = 0, beats_acc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected beat for every beat the DUT hands over.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("beat_data", 64'(out_pes_data), 64'(mon_e.data));
        chk("beat_wv",   64'(out_word_valid), 64'(mon_e.wv));
        chk("beat_src",  64'(out_src_idx), 64'(mon_e.src));
        chk("beat_last", 64'(out_last), 64'(mon_e.last));
      end
    end
  end

  function automatic logic [7:0] tagb(input int tag);
    return 8'(tag * 77);
  endfunction

  task automatic push_full(input int tag);
    exp_t e;
    for (int k = 0; k < NP; k++) begin
      e = '0;
      for (int p = 0; p < NP; p++) e.data[W*p +: W] = 8'(16*k + p) ^ tagb(tag);
      e.wv = 4'hF; e.src = NL'(k); e.last = (k == NP-1);
      q.push_back(e);
    end
  endtask

  task automatic push_g2();
    exp_t e;
    for (int k = 0; k < NP; k++) begin
      e = '0;
      for (int p = 0; p < NP; p++)
        if ((k >> 1) == (p >> 1)) begin
          e.data[W*p +: W] = 8'(128 + 16*k + p);
          e.wv[p] = 1'b1;
        end
      e.src = NL'(k); e.last = (k == NP-1);
      q.push_back(e);
    end
  endtask

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_beat(input logic [W*NP-1:0] d, input logic [NL*NP-1:0] c);
    int n = 0;
    in_pes_data = d; in_src_connectivity = c; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      stall_cnt++; n++;
      @(negedge clk);
    end
    if (n >= 200) chk("in_ready_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 0;
    beats_acc++;
  endtask

  // kind 0: full group, PE p from (p+t)%4; kind 1: pairs, later copy offset by 0x80.
  task automatic send_frame(input int tag, input int kind, input int nbeats);
    logic [W*NP-1:0] d;
    logic [NL*NP-1:0] c;
    int src;
    for (int t = 0; t < nbeats; t++) begin
      for (int p = 0; p < NP; p++) begin
        if (kind == 0) begin
          src = (p + t) % NP;
          d[W*p +: W] = 8'(16*src + p) ^ tagb(tag);
        end else begin
          src = (p & 2) + ((p + t) & 1);
          d[W*p +: W] = 8'(16*src + p + ((t >= 2) ? 128 : 0));
        end
        c[NL*p +: NL] = NL'(src);
      end
      send_beat(d, c);
    end
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) chk("drain_timeout", 1, 0);
    chk("drain_empty", 64'(q.size()), 0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_last", 64'(out_last), 0);
    chk("rst_word_valid", 64'(out_word_valid), 0);
    chk("rst_pes_data", 64'(out_pes_data), 0);
    chk("rst_src_idx", 64'(out_src_idx), 0);
    chk("rst_frames_done", 64'(frames_done), 0);
  endtask

  // Asserts reset between clock edges and checks outputs before any edge.
  task automatic do_reset();
    #3 rst = 1;
    #1 chk_reset_outs();
    q.delete();
    @(posedge clk); @(posedge clk); #1 rst = 0;
  endtask

  initial begin
    #1 rst = 1;
    #1 chk_reset_outs();
    @(posedge clk); @(posedge clk); #1 rst = 0;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 1);
    chk("idle_out_valid", 64'(out_valid), 0);
    chk("idle_frames_done", 64'(frames_done), 0);

    // Full-group frame
    align();
    push_full(0);
    send_frame(0, 0, 4);
    @(negedge clk);
    chk("full_latency_valid", 64'(out_valid), 1);
    align(); out_ready = 1;
    drain();
    chk("full_frames_done", 64'(frames_done), 1);

    // Group size 2
    align();
    push_g2();
    send_frame(0, 1, 4);
    drain();
    chk("g2_frames_done", 64'(frames_done), 2);

    // Backpressure, three frames back-to-back
    align(); out_ready = 0;
    push_full(1); send_frame(1, 0, 4);
    push_full(2); send_frame(2, 0, 4);
    fork
      begin
        push_full(3); send_frame(3, 0, 4);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready_low", 64'(in_ready), 0);
        end
        @(posedge clk); #1 out_ready = 1;
        repeat (4) @(negedge clk);
        chk("bp_out_last", 64'(out_last), 1);
        chk("bp_in_ready_still_low", 64'(in_ready), 0);
        @(posedge clk); #1 out_ready = 0;
        @(negedge clk);
        chk("bp_in_ready_back", 64'(in_ready), 1);
        chk("bp_frames_done1", 64'(frames_done), 3);
      end
    join
    @(negedge clk);
    chk("bp_full_again", 64'(in_ready), 0);
    align(); out_ready = 1;
    drain();
    chk("bp_frames_done", 64'(frames_done), 5);

    // Continuous streaming from a clean reset
    do_reset();
    out_ready = 1; stall_cnt = 0; beats_acc = 0;
    fork
      for (int f = 0; f < 10; f++) begin
        push_full(f + 10);
        send_frame(f + 10, 0, 4);
      end
      begin
        int n = 0;
        while (beats_acc < 4 && n < 100) begin @(negedge clk); n++; end
        chk("stream_first_valid", 64'(out_valid), 1);
      end
    join
    drain();
    chk("stream_frames_done", 64'(frames_done), 10);
    chk("stream_no_stall", 64'(stall_cnt), 0);

    // Reset during frame 2 fill with frame 1 half drained
    align(); out_ready = 0;
    push_full(5); send_frame(5, 0, 4);
    fork
      send_frame(6, 0, 2);
      begin
        out_ready = 1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 out_ready = 0;
      end
    join
    @(negedge clk);
    chk("mid_out_valid", 64'(out_valid), 1);
    chk("mid_src_idx", 64'(out_src_idx), 2);
    do_reset();
    @(negedge clk);
    chk("post_rst_out_valid", 64'(out_valid), 0);
    chk("post_rst_frames_done", 64'(frames_done), 0);
    chk("post_rst_in_ready", 64'(in_ready), 1);
    align(); out_ready = 1;
    push_full(7); send_frame(7, 0, 4);
    drain();
    chk("post_rst_frame", 64'(frames_done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/xconnect_gather.md
# xconnect_gather

Receive-side reorder buffer for the xconnect butterfly interconnect. The interconnect delivers one word per PE per cycle, in counter-dependent source order, with a per-PE source index. This block collects NOF_PES beats per PE into a double-buffered store and replays each frame in ascending source order. Downstream PE logic therefore sees a deterministic "word from PE k" sequence. It sits directly after the interconnect's registered data and connectivity outputs.

## Interface
- WORD_SIZE, 256, bits per PE word
- NOF_PES, 16, number of PEs; power of two, ≥2
- NOF_LEVELS, $clog2(NOF_PES), width of a source index / beat counter
- clk  input  1  clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  beat present on in_pes_data / in_src_connectivity
- in_ready  output  1  block can accept a beat this cycle
- in_pes_data  input  WORD_SIZE*NOF_PES  PE p word at [WORD_SIZE*p +: WORD_SIZE]
- in_src_connectivity  input  NOF_LEVELS*NOF_PES  source index of PE p word at [NOF_LEVELS*p +: NOF_LEVELS]
- out_valid  output  1  reordered beat available
- out_ready  input  1  downstream accepts beat
- out_pes_data  output  WORD_SIZE*NOF_PES  PE p word received from source out_src_idx
- out_word_valid  output  NOF_PES  bit p set if PE p received a word from source out_src_idx this frame
- out_src_idx  output  NOF_LEVELS  source index of current output beat (0..NOF_PES-1)
- out_last  output  1  final beat of a frame
- frames_done  output  16  count of fully drained frames, wraps at 2^16

## Operation
- Storage: 2 banks × NOF_PES PEs × NOF_PES source slots of WORD_SIZE. Each (bank, PE) has a NOF_PES-bit filled bitmap. Data storage is not reset; bitmaps are.
- Bank state: bank_full[1:0], wr_bank, rd_bank (1 bit each), wr_cnt and rd_cnt (NOF_LEVELS bits each).
- in_ready = ~bank_full[wr_bank], decoded from registered state only.
- Write beat (in_valid & in_ready):
  - For every PE p, mem[wr_bank][p][src_p] <= word_p and filled[wr_bank][p][src_p] <= 1.
  - A repeated source within a frame overwrites the slot; last write wins. This is normal for group sizes < NOF_PES.
  - wr_cnt increments.
  - When wr_cnt == NOF_PES-1: bank_full[wr_bank] <= 1, wr_bank toggles, wr_cnt wraps to 0.
- in_valid while in_ready=0: the beat is ignored. The upstream must hold it. The interconnect counter keeps running, so the system guarantees drain bandwidth.
- Read side:
  - out_valid = bank_full[rd_bank].
  - out_src_idx = rd_cnt.
  - out_pes_data[p] = mem[rd_bank][p][rd_cnt] when out_valid, else all zeros.
  - out_word_valid[p] = filled[rd_bank][p][rd_cnt] & out_valid.
  - out_last = out_valid & (rd_cnt == NOF_PES-1).
- Read beat (out_valid & out_ready):
  - rd_cnt increments.
  - On the last beat: bank_full[rd_bank] <= 0, all filled bitmaps of rd_bank <= 0, rd_bank toggles, rd_cnt wraps to 0, frames_done increments.
- Both banks full: in_ready=0 until one bank drains.
- Simultaneous last write and last read on the same bank are impossible: a bank is written only when empty and read only when full.
- Last read freeing bank B, in the same cycle as in_valid, with wr_bank==B blocked: no write that cycle. in_ready rises the next cycle.

## Timing
- Reset values:
  - in_ready=1; out_valid=0; out_last=0; out_word_valid=0; out_pes_data=0; out_src_idx=0; frames_done=0.
  - wr_bank=rd_bank=0; wr_cnt=rd_cnt=0; bank_full=00; all bitmaps 0.
- Reset asserted mid-frame: partial write frame and undrained frames are discarded. Outputs take reset values asynchronously.
- Latency: final input beat of a frame accepted at edge T → out_valid=1 after edge T, i.e. first reordered beat presented in cycle T+1.
- Throughput: 1 beat/cycle in and out sustained, with out_ready held high.
- Output path is a combinational mux from registered storage; no data register stage.

## Test plan
Benches run with NOF_PES=4 and WORD_SIZE=8.
- Reset, then idle → in_ready=1, out_valid=0, frames_done=0. Assert rst asynchronously mid-cycle → all outputs return to reset values without a clock edge.
- Full-group frame: 4 beats where PE p receives from src (p+t)%4 at beat t, word = 0x10*src+p. After the 4th beat, out_valid=1. Beat k gives out_pes_data[p]=0x10*k+p, out_word_valid=4'hF, out_last only at k=3, then frames_done=1.
- Group size 2: PE p receives a source from its pair at every beat, each source twice, with the later word different. Output for out-of-pair sources: out_word_valid bit=0, data 0. In-pair sources return the second-written value.
- Backpressure: out_ready=0, stream 3 frames back-to-back.
  - Frames 1 and 2 are accepted; in_ready drops after beat 8.
  - Raise out_ready for 4 cycles. Frame 1 drains and in_ready returns the cycle after out_last.
  - Frame 3 is accepted. Output order is frame 1, 2, 3, with no beat lost or duplicated.
- Continuous streaming: out_ready=1, 10 frames → in_ready never drops, frames_done=10, first out_valid 1 cycle after the 4th input beat.
- Reset during frame 2 fill, with frame 1 partially drained → after release: out_valid=0, frames_done=0. A new frame is then received and reordered correctly.
